// File: rtl/halut_lut_accumulator.sv
// LUT read-side accumulator: turns a stream of per-codebook prototype indices
// into LUT reads and sums the signed entries into one result per vector.
// Two-stage pipeline: stage 1 registers the read address, stage 2 consumes
// the combinational read data into the accumulator / result register.
module halut_lut_accumulator #(
  parameter int unsigned C              = 32,
  parameter int unsigned K              = 16,
  parameter int unsigned DataTypeWidth  = 16,
  parameter int unsigned IdxWidth       = $clog2(K),
  parameter int unsigned TotalAddrWidth = $clog2(C * K),
  parameter int unsigned AccWidth       = DataTypeWidth + $clog2(C)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      enc_valid_i,
  output logic                      enc_ready_o,
  input  logic [IdxWidth-1:0]       enc_idx_i,
  output logic [TotalAddrWidth-1:0] raddr_o,
  input  logic [DataTypeWidth-1:0]  rdata_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [AccWidth-1:0]       res_data_o,
  output logic                      busy_o
);

  localparam int unsigned CntWidth = $clog2(C);
  localparam int unsigned ExtWidth = AccWidth - DataTypeWidth;
  localparam logic [CntWidth-1:0] LastCb = CntWidth'(C - 1);

  logic [CntWidth-1:0] c_q;
  logic                s1_valid;
  logic                s1_first;
  logic                s1_last;
  logic [AccWidth-1:0] acc;
  logic [AccWidth-1:0] ext;
  logic [AccWidth-1:0] sum;
  logic                stall;
  logic                accept;
  logic                s2_fire;

  // Only a finished vector that cannot land in an occupied result register
  // stalls; partial beats keep flowing even while a result waits.
  assign stall       = res_valid_o & ~res_ready_i & s1_valid & s1_last;
  assign enc_ready_o = ~stall & ~flush_i;
  assign accept      = enc_valid_i & enc_ready_o;
  // A flush also drops whatever sits in stage 1, so stage 2 is suppressed.
  assign s2_fire     = s1_valid & ~stall & ~flush_i;
  assign ext         = {{ExtWidth{rdata_i[DataTypeWidth-1]}}, rdata_i};
  assign sum         = s1_first ? ext : acc + ext;
  assign busy_o      = (c_q != '0) | s1_valid | res_valid_o;

  // Codebook position of the next beat; wraps after the last codebook.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q <= '0;
    end else if (flush_i) begin
      c_q <= '0;
    end else if (accept) begin
      c_q <= (c_q == LastCb) ? '0 : c_q + CntWidth'(1);
    end
  end

  // Stage 1: register the LUT address and tag the beat; hold while stalled
  // so the LUT data seen by stage 2 stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raddr_o  <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        raddr_o  <= {c_q, enc_idx_i};
        s1_first <= (c_q == '0);
        s1_last  <= (c_q == LastCb);
      end
    end
  end

  // Stage 2: running sum of sign-extended LUT entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc <= '0;
    end else if (flush_i) begin
      acc <= '0;
    end else if (s2_fire) begin
      acc <= sum;
    end
  end

  // Result register: a new result may replace one consumed in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
    end else if (s2_fire && s1_last) begin
      res_valid_o <= 1'b1;
      res_data_o  <= sum;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/halut_lut_accumulator.md
# halut_lut_accumulator

Downstream read-side consumer of the latch-based LUT memory (`scm`). It accepts a stream of encoded prototype indices, one per codebook. For each index it drives the LUT read address `{codebook, index}` and sign-extends and sums the returned LUT entries over all `C` codebooks. Each finished dot-product approximation is emitted on a valid/ready result port. The block issues reads only and never writes the LUT; the owning controller must not write the LUT while the accumulator is busy.

## Interface
Parameters:
- `C`, 32: codebooks per vector; power of two, ≥2.
- `K`, 16: prototypes per codebook; power of two, ≥2.
- `DataTypeWidth`, 16: LUT entry width; signed two's complement.
- `IdxWidth`, `$clog2(K)`: encoded index width.
- `TotalAddrWidth`, `$clog2(C*K)`: LUT address width.
- `AccWidth`, `DataTypeWidth + $clog2(C)`: result width; the sum cannot overflow.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `flush_i`, in, 1: synchronous abort of the partial vector.
- `enc_valid_i`, in, 1: index beat valid.
- `enc_ready_o`, out, 1: index beat accepted when both valid and ready are high.
- `enc_idx_i`, in, `IdxWidth`: prototype index for the current codebook.
- `raddr_o`, out, `TotalAddrWidth`: LUT read address, registered.
- `rdata_i`, in, `DataTypeWidth`: LUT read data, combinational from `raddr_o`.
- `res_valid_o`, out, 1: result valid.
- `res_ready_i`, in, 1: result consumed.
- `res_data_o`, out, `AccWidth`: signed sum of `C` LUT entries.
- `busy_o`, out, 1: high while a partial vector, a pipeline beat or an unconsumed result exists.

## Operation
- **Codebook counter `c_q`** (0..C-1):
  - Increments on each accepted beat.
  - Wraps from C-1 to 0; beat C-1 is tagged `last`, beat 0 is tagged `first`.
- **Stage 1:**
  - On an accepted beat, register `raddr_o <= {c_q, enc_idx_i}`.
  - Set `s1_valid`, `s1_first` and `s1_last`.
- **Stage 2** (the cycle after stage 1, when `s1_valid` is set and the pipeline is not stalled):
  - Compute `ext = sign_extend(rdata_i, AccWidth)`.
  - If `s1_first`: `acc <= ext`; otherwise `acc <= acc + ext`.
  - If `s1_last`: `res_data_o <= (first ? ext : acc + ext)` and `res_valid_o <= 1`. `acc` is don't-care afterwards.
- **Result port:**
  - `res_valid_o` clears when `res_ready_i` is high and no new result loads in the same cycle.
  - Load and consume in the same cycle: the new result replaces the old one and `res_valid_o` stays 1.
- **Stall:**
  - `stall = res_valid_o & ~res_ready_i & s1_valid & s1_last`.
  - While stalled, `enc_ready_o = 0` and `raddr_o`, `s1_*` and `acc` hold. Because `raddr_o` is held, `rdata_i` stays stable.
- **Ready:** `enc_ready_o = ~stall & ~flush_i`.
- **Flush** (`flush_i` = 1):
  - `c_q <= 0`, `s1_valid <= 0`, `acc <= 0`.
  - The result register and `res_valid_o` are unaffected.
  - No beat is accepted in that cycle.
- **Arithmetic:** LUT entries are treated as signed. Addition wraps modulo 2^AccWidth; no saturation is needed by construction.

## Timing
- **Reset values:** `enc_ready_o = 1`, `raddr_o = 0`, `res_valid_o = 0`, `res_data_o = 0`, `busy_o = 0`. Internally `c_q = 0`, `acc = 0`, `s1_valid = 0`.
- **Throughput:** one index per cycle, sustained across vector boundaries with no bubble between vectors.
- **Latency:** last beat accepted in cycle t → `raddr_o` updated in cycle t+1 → `res_valid_o` high in cycle t+2.
- **Reset mid-vector:** asserting `rst_ni` low clears everything immediately, including any pending result.
- **`busy_o`:** equals `(c_q != 0) | s1_valid | res_valid_o`.

## Test plan
- **Single vector:** C=4, K=4, LUT[c*4+k] = 10*c+k; indices 1,2,3,0 with no stalls. Required: reads at addresses 1, 6, 11, 12; `res_data_o` = 1+12+23+30 = 66; `res_valid_o` high exactly 2 cycles after the 4th handshake.
- **Signed entries:** all LUT entries = 16'hFFFF (−1), C=32. Required: result = −32 = all-ones in AccWidth except the low 5 bits (value 2^21−32); no overflow.
- **Back-to-back with backpressure:** two vectors streamed contiguously; `res_ready_i` = 0 for 5 cycles after the first result. Required:
  - `enc_ready_o` drops only while the second vector's last beat waits in stage 1.
  - Both results are correct and delivered in order; no beat is lost or duplicated.
- **Flush mid-vector:** after 2 of 4 beats, pulse `flush_i`, then send a full vector 1,1,1,1. Required: the result covers only the new vector; `c_q` restarts at 0.
- **Async reset:** hold `res_valid_o` = 1 with `res_ready_i` = 0, then pulse `rst_ni` low. Required: `res_valid_o`, `busy_o` and `raddr_o` read 0 immediately, and the next vector is computed from codebook 0.
